// File: rtl/fir_pkg.sv
// fir_pkg: shared types for the FIR sample feeder.
// Holds the default sample width, the feeder state enum and the sample type.
package fir_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STREAM,
      ST_GAP_WAIT,
      ST_DRAIN,
      ST_FINISH
   } feeder_state_t;

   typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_sample_mem.sv
// fir_sample_mem: DEPTH x DATA_W sample register file.
// Ports: clk, i_we/i_waddr/i_wdata (sync write), i_raddr/o_rdata (async read).
module fir_sample_mem #(
   parameter int  DATA_W = 16,
   parameter int  DEPTH  = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [AW-1:0]            i_waddr,
   input  logic signed [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]            i_raddr,
   output logic signed [DATA_W-1:0] o_rdata
);
   import fir_pkg::*;

   logic signed [DATA_W-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Write-through: a write landing this edge is seen by the reader,
   // so a sample written together with start is the one streamed.
   assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata
                                                   : r_mem[i_raddr];

endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: streams a buffered sample block into a FIR, with
// optional inter-sample gaps and a zero drain. Optional macro:
// FIR_FEEDER_LOOP_EN adds input loop (wrap to index 0 instead of draining).
// Ports: clk, RST (async, active-low), wr_en/wr_addr/wr_data (buffer load),
// len/start (stream request), in_data/EN (FIR feed), busy, done,
// sample_idx (index of the sample on in_data).
module fir_sample_feeder #(
   parameter int  DATA_W       = 16,
   parameter int  DEPTH        = 16,
   parameter int  GAP          = 0,
   parameter int  DRAIN_CYCLES = 8,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [AW:0]              len,
   input  logic                     start,
`ifdef FIR_FEEDER_LOOP_EN
   input  logic                     loop,
`endif
   output logic signed [DATA_W-1:0] in_data,
   output logic                     EN,
   output logic                     busy,
   output logic                     done,
   output logic [AW-1:0]            sample_idx
);
   import fir_pkg::*;

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LD =
      (GAP > 0) ? GW'(GAP - 1) : '0;
   localparam logic [CW-1:0] DRN_LD =
      (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   feeder_state_t r_state;
   feeder_state_t w_state_n;

   logic signed [DATA_W-1:0] r_data;
   logic signed [DATA_W-1:0] w_data_n;
   logic                     r_en;
   logic                     w_en_n;
   logic                     r_busy;
   logic                     w_busy_n;
   logic                     r_done;
   logic                     w_done_n;
   logic [AW-1:0]            r_idx;
   logic [AW-1:0]            w_idx_n;
   logic [AW:0]              r_len;
   logic [AW:0]              w_len_n;
   logic [GW-1:0]            r_gap_cnt;
   logic [GW-1:0]            w_gap_n;
   logic [CW-1:0]            r_drn_cnt;
   logic [CW-1:0]            w_drn_n;

   logic [AW:0]              w_len_eff;
   logic [AW:0]              w_len_m1;
   logic                     w_last;
   logic                     w_end;
   logic [AW-1:0]            w_next_idx;
   logic [AW-1:0]            w_rd_addr;
   logic signed [DATA_W-1:0] w_rd_data;
   logic                     w_we;

   assign w_len_eff = (len > DEPTH_L) ? DEPTH_L : len;
   assign w_len_m1  = r_len - 1'b1;
   assign w_last    = ({1'b0, r_idx} == w_len_m1);

`ifdef FIR_FEEDER_LOOP_EN
   assign w_end      = w_last && !loop;
   assign w_next_idx = w_last ? '0 : r_idx + 1'b1;
`else
   assign w_end      = w_last;
   assign w_next_idx = r_idx + 1'b1;
`endif

   // IDLE always fetches the first sample; elsewhere the upcoming one.
   assign w_rd_addr = (r_state == ST_IDLE) ? '0 : w_next_idx;

   // Buffer is write-protected while a stream is in flight.
   assign w_we = wr_en && (r_state == ST_IDLE);

   fir_sample_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (wr_addr),
      .i_wdata (wr_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   always_comb begin
      w_state_n = r_state;
      w_data_n  = '0;
      w_en_n    = 1'b0;
      w_busy_n  = 1'b1;
      w_done_n  = 1'b0;
      w_idx_n   = '0;
      w_len_n   = r_len;
      w_gap_n   = r_gap_cnt;
      w_drn_n   = r_drn_cnt;
      unique case (r_state)
         ST_IDLE: begin
            w_busy_n = 1'b0;
            if (start) begin
               w_len_n  = w_len_eff;
               w_busy_n = 1'b1;
               if (w_len_eff == '0) begin
                  w_state_n = ST_FINISH;
                  w_done_n  = 1'b1;
               end else begin
                  w_state_n = ST_STREAM;
                  w_data_n  = w_rd_data;
                  w_en_n    = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (w_end) begin
               if (DRAIN_CYCLES > 0) begin
                  w_state_n = ST_DRAIN;
                  w_en_n    = 1'b1;
                  w_drn_n   = DRN_LD;
               end else begin
                  w_state_n = ST_FINISH;
                  w_done_n  = 1'b1;
               end
            end else if (GAP > 0) begin
               // Hold the current sample on in_data during the gap.
               w_state_n = ST_GAP_WAIT;
               w_idx_n   = r_idx;
               w_data_n  = r_data;
               w_gap_n   = GAP_LD;
            end else begin
               w_idx_n  = w_next_idx;
               w_data_n = w_rd_data;
               w_en_n   = 1'b1;
            end
         end
         ST_GAP_WAIT: begin
            if (r_gap_cnt == '0) begin
               w_state_n = ST_STREAM;
               w_idx_n   = w_next_idx;
               w_data_n  = w_rd_data;
               w_en_n    = 1'b1;
            end else begin
               w_gap_n  = r_gap_cnt - 1'b1;
               w_idx_n  = r_idx;
               w_data_n = r_data;
            end
         end
         ST_DRAIN: begin
            if (r_drn_cnt == '0) begin
               w_state_n = ST_FINISH;
               w_done_n  = 1'b1;
            end else begin
               w_drn_n = r_drn_cnt - 1'b1;
               w_en_n  = 1'b1;
            end
         end
         ST_FINISH: begin
            w_state_n = ST_IDLE;
            w_busy_n  = 1'b0;
         end
         default: begin
            w_state_n = ST_IDLE;
            w_busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_data    <= '0;
         r_en      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_idx     <= '0;
         r_len     <= '0;
         r_gap_cnt <= '0;
         r_drn_cnt <= '0;
      end else begin
         r_data    <= w_data_n;
         r_en      <= w_en_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
         r_idx     <= w_idx_n;
         r_len     <= w_len_n;
         r_gap_cnt <= w_gap_n;
         r_drn_cnt <= w_drn_n;
      end
   end

   assign in_data    = r_data;
   assign EN         = r_en;
   assign busy       = r_busy;
   assign done       = r_done;
   assign sample_idx = r_idx;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed bench for fir_sample_feeder.
// u0 runs with GAP=0, u2 with GAP=2; both DEPTH=16, DRAIN_CYCLES=8.
module tb_fir_sample_feeder;

   localparam int DW = 16;
   localparam int AW = 4;

   logic                 clk     = 1'b0;
   logic                 RST     = 1'b0;
   logic                 wr_en   = 1'b0;
   logic [AW-1:0]        wr_addr = '0;
   logic signed [DW-1:0] wr_data = '0;
   logic [AW:0]          len     = '0;
   logic                 start0  = 1'b0;
   logic                 start2  = 1'b0;
   logic                 loop    = 1'b0;

   logic signed [DW-1:0] d0, d2;
   logic                 en0, en2, busy0, busy2, done0, done2;
   logic [AW-1:0]        idx0, idx2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fir_sample_feeder #(
      .DATA_W(DW), .DEPTH(16), .GAP(0), .DRAIN_CYCLES(8)
   ) u0 (
      .clk(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .len(len), .start(start0),
`ifdef FIR_FEEDER_LOOP_EN
      .loop(loop),
`endif
      .in_data(d0), .EN(en0), .busy(busy0), .done(done0),
      .sample_idx(idx0)
   );

   fir_sample_feeder #(
      .DATA_W(DW), .DEPTH(16), .GAP(2), .DRAIN_CYCLES(8)
   ) u2 (
      .clk(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .len(len), .start(start2),
`ifdef FIR_FEEDER_LOOP_EN
      .loop(1'b0),
`endif
      .in_data(d2), .EN(en2), .busy(busy2), .done(done2),
      .sample_idx(idx2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = DW'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      int n_en, n_done, done_at, n_smp;
      int en_e [16];
      int dt_e [16];
      int ix_e [16];

      // Reset state
      repeat (2) tick();
      chk("rst data", d0, 0);
      chk("rst en", en0, 0);
      chk("rst busy", busy0, 0);
      chk("rst done", done0, 0);
      chk("rst idx", idx0, 0);
      RST = 1'b1;
      tick();

      // len=8, GAP=0: 8 samples then 8 zeros, done 17 cycles on
      for (int i = 0; i < 8; i++) wr(i, i);
      len    = 5'd8;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      n_en = 0; n_done = 0; done_at = -1;
      for (int k = 0; k < 18; k++) begin
         if (k < 16) begin
            chk($sformatf("t1 data[%0d]", k), d0, (k < 8) ? k : 0);
            chk($sformatf("t1 en[%0d]", k), en0, 1);
         end
         if (en0) n_en++;
         if (done0) begin
            n_done++;
            done_at = k;
         end
         tick();
      end
      chk("t1 en count", n_en, 16);
      chk("t1 done count", n_done, 1);
      chk("t1 done cycle", done_at, 16);
      chk("t1 idle busy", busy0, 0);

      // GAP=2 on u2; address 0 written in the start cycle
      wr(1, -3);
      wr(2, 9);
      len     = 5'd3;
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = 16'sd5;
      start2  = 1'b1;
      tick();
      wr_en   = 1'b0;
      start2  = 1'b0;
      en_e = '{1,0,0,1,0,0,1,1,1,1,1,1,1,1,1,0};
      dt_e = '{5,5,5,-3,-3,-3,9,0,0,0,0,0,0,0,0,0};
      ix_e = '{0,0,0,1,1,1,2,0,0,0,0,0,0,0,0,0};
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("t2 en[%0d]", k), en2, en_e[k]);
         chk($sformatf("t2 data[%0d]", k), d2, dt_e[k]);
         chk($sformatf("t2 idx[%0d]", k), idx2, ix_e[k]);
         chk($sformatf("t2 done[%0d]", k), done2, (k == 15) ? 1 : 0);
         tick();
      end
      chk("t2 idle busy", busy2, 0);

      // len=0: one busy cycle carrying done, no EN
      len    = 5'd0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("t3 busy", busy0, 1);
      chk("t3 en", en0, 0);
      chk("t3 done", done0, 1);
      tick();
      chk("t3 busy after", busy0, 0);
      chk("t3 done after", done0, 0);
      chk("t3 en after", en0, 0);

      // len=20 clamps to 16; mid-stream start/write ignored
      for (int i = 0; i < 16; i++) wr(i, 100 + i);
      len    = 5'd20;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      n_smp = 0; n_done = 0;
      for (int k = 0; k < 26; k++) begin
         if (k < 16)
            chk($sformatf("t4 data[%0d]", k), d0, 100 + k);
         if (en0 && d0 != 0) n_smp++;
         if (done0) n_done++;
         if (k == 5) begin
            wr_en   = 1'b1;
            wr_addr = 4'd3;
            wr_data = 16'sd777;
            start0  = 1'b1;
         end
         tick();
         wr_en  = 1'b0;
         start0 = 1'b0;
      end
      chk("t4 samples", n_smp, 16);
      chk("t4 done count", n_done, 1);
      len    = 5'd4;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4 replay[%0d]", k), d0, 100 + k);
         tick();
      end
      repeat (10) tick();
      chk("t4 end busy", busy0, 0);

      // Reset mid-stream, then replay from the untouched buffer
      len    = 5'd8;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (4) tick();
      chk("t5 pre data", d0, 104);
      RST = 1'b0;
      #1;
      chk("t5 data", d0, 0);
      chk("t5 en", en0, 0);
      chk("t5 busy", busy0, 0);
      chk("t5 done", done0, 0);
      chk("t5 idx", idx0, 0);
      repeat (2) tick();
      RST = 1'b1;
      n_done = 0;
      for (int k = 0; k < 30; k++) begin
         if (done0) n_done++;
         tick();
      end
      chk("t5 no done", n_done, 0);
      chk("t5 idle busy", busy0, 0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t5 replay[%0d]", k), d0, 100 + k);
         tick();
      end
      repeat (10) tick();

`ifdef FIR_FEEDER_LOOP_EN
      // Loop over 4 samples, drop loop during the 3rd pass
      loop   = 1'b1;
      len    = 5'd4;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k < 22; k++) begin
         if (k < 12)
            chk($sformatf("t6 data[%0d]", k), d0, 100 + (k % 4));
         else if (k < 20)
            chk($sformatf("t6 drain[%0d]", k), d0, 0);
         chk($sformatf("t6 en[%0d]", k), en0, (k < 20) ? 1 : 0);
         chk($sformatf("t6 done[%0d]", k), done0, (k == 20) ? 1 : 0);
         if (k == 9) loop = 1'b0;
         tick();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
